// File: rtl/cam_capture_pkg.sv
// rtl/cam_capture_pkg.sv - shared types and default widths for the DVP capture front-end
package cam_capture_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int BPP_DEF    = 2;
   localparam int H_MAX_DEF  = 640;
   localparam int V_MAX_DEF  = 480;
   localparam int PIX_W_DEF  = DATA_W_DEF * BPP_DEF;
   localparam int X_W_DEF    = $clog2(H_MAX_DEF);
   localparam int Y_W_DEF    = $clog2(V_MAX_DEF);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FRAME,
      ST_LINE
   } state_t;

   // Pixel record at the default geometry; the top builds its own from its parameters.
   typedef struct packed {
      logic [PIX_W_DEF-1:0] data;
      logic [X_W_DEF-1:0]   x;
      logic [Y_W_DEF-1:0]   y;
      logic                 sof;
      logic                 eol;
   } pix_rec_t;

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cam_sync_fifo.sv
// rtl/cam_sync_fifo.sv - show-ahead synchronous FIFO of packed pixel records
module cam_sync_fifo
   import cam_capture_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         res,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         full,
   output logic         empty
);

   localparam int AW = clog2_min1(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         do_rd;
   logic         do_wr;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_rd   = rd_en & ~empty;
   // A read in the same cycle frees the slot, so a write into a full FIFO still lands.
   assign do_wr   = wr_en & (~full | do_rd);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (res) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/cam_capture_frontend.sv
// rtl/cam_capture_frontend.sv - DVP camera capture: sync, pixel assembly, crop, FIFO stream
// Window cropping is compiled in when CAM_CAPTURE_CROP_EN is defined.
module cam_capture_frontend
   import cam_capture_pkg::*;
#(
   parameter int DATA_W        = DATA_W_DEF,
   parameter int BYTES_PER_PIX = BPP_DEF,
   parameter int XCLK_DIV      = 4,
   parameter int H_MAX         = H_MAX_DEF,
   parameter int V_MAX         = V_MAX_DEF,
   parameter int FIFO_DEPTH    = 8
) (
   input  logic                            clk,
   input  logic                            res,
   output logic                            xclk,
   input  logic                            cam_href,
   input  logic                            cam_vsync,
   input  logic                            cam_pclk,
   input  logic [DATA_W-1:0]               cam_data,
   input  logic                            enable,
   input  logic [$clog2(H_MAX)-1:0]        win_x0,
   input  logic [$clog2(H_MAX)-1:0]        win_x1,
   input  logic [$clog2(V_MAX)-1:0]        win_y0,
   input  logic [$clog2(V_MAX)-1:0]        win_y1,
   output logic [DATA_W*BYTES_PER_PIX-1:0] pix_data,
   output logic [$clog2(H_MAX)-1:0]        pix_x,
   output logic [$clog2(V_MAX)-1:0]        pix_y,
   output logic                            pix_sof,
   output logic                            pix_eol,
   output logic                            pix_valid,
   input  logic                            pix_ready,
   output logic                            busy,
   output logic                            overflow,
   input  logic                            clear_ovf,
   output logic [15:0]                     frame_cnt
);

   localparam int PW   = DATA_W * BYTES_PER_PIX;
   localparam int XW   = $clog2(H_MAX);
   localparam int YW   = $clog2(V_MAX);
   localparam int PHW  = clog2_min1(BYTES_PER_PIX);
   localparam int HALF = XCLK_DIV / 2;
   localparam int XCW  = clog2_min1(HALF);

   // Counters carry one extra bit so they can park at H_MAX / V_MAX (out of range).
   localparam logic [XW:0]    H_LIM  = (XW+1)'(H_MAX);
   localparam logic [XW:0]    H_LAST = (XW+1)'(H_MAX - 1);
   localparam logic [YW:0]    V_LIM  = (YW+1)'(V_MAX);
   localparam logic [PHW-1:0] PH_END = PHW'(BYTES_PER_PIX - 1);

   typedef struct packed {
      logic [PW-1:0] data;
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic          sof;
      logic          eol;
   } rec_t;

   localparam int RW = $bits(rec_t);

   logic [XCW-1:0]    xdiv;
   logic [1:0]        href_sr, vsync_sr, pclk_sr;
   logic [DATA_W-1:0] data_m, data_s;
   logic              pclk_p, vsync_p;
   logic              href_s, pclk_rise, vs_rise, vs_fall;

   state_t            state, state_n;
   logic              cap, start_frame, end_line, abort;
   logic [PHW-1:0]    phase, phase_cur;
   logic [PW-1:0]     shreg, pix_word;
   logic [XW:0]       x_cnt, x_cur;
   logic [YW:0]       y_cnt;
   logic              sof_pend, pix_done, in_range, in_win, eol_px, fwd;

   rec_t              new_rec, pend_rec, wr_rec, rd_rec, out_rec;
   logic              pend_valid, pend_valid_n, wr_en;
   logic [RW-1:0]     rd_bits;
   logic              full, empty;

   always_ff @(posedge clk) begin
      if (res) begin
         xdiv <= '0;
         xclk <= 1'b0;
      end else if (xdiv == XCW'(HALF - 1)) begin
         xdiv <= '0;
         xclk <= ~xclk;
      end else begin
         xdiv <= xdiv + XCW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (res) begin
         href_sr  <= '0;
         vsync_sr <= '0;
         pclk_sr  <= '0;
         data_m   <= '0;
         data_s   <= '0;
         pclk_p   <= 1'b0;
         vsync_p  <= 1'b0;
      end else begin
         href_sr  <= {href_sr[0], cam_href};
         vsync_sr <= {vsync_sr[0], cam_vsync};
         pclk_sr  <= {pclk_sr[0], cam_pclk};
         data_m   <= cam_data;
         data_s   <= data_m;
         pclk_p   <= pclk_sr[1];
         vsync_p  <= vsync_sr[1];
      end
   end

   assign href_s    = href_sr[1];
   assign pclk_rise = pclk_sr[1] & ~pclk_p;
   assign vs_rise   = vsync_sr[1] & ~vsync_p;
   assign vs_fall   = ~vsync_sr[1] & vsync_p;

   always_comb begin
      state_n     = state;
      cap         = 1'b0;
      start_frame = 1'b0;
      end_line    = 1'b0;
      abort       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (vs_fall && enable) begin
               state_n     = ST_FRAME;
               start_frame = 1'b1;
            end
         end
         ST_FRAME: begin
            if (vs_rise) begin
               state_n = ST_IDLE;
            end else if (pclk_rise && href_s) begin
               state_n = ST_LINE;
               cap     = 1'b1;
            end
         end
         ST_LINE: begin
            if (vs_rise) begin
               state_n = ST_IDLE;
               abort   = 1'b1;
            end else if (!href_s) begin
               state_n  = ST_FRAME;
               end_line = 1'b1;
            end else if (pclk_rise) begin
               cap = 1'b1;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // The byte that moves FRAME->LINE is the first of the line: phase and column restart.
   assign phase_cur = (state == ST_FRAME) ? '0 : phase;
   assign x_cur     = (state == ST_FRAME) ? '0 : x_cnt;
   assign pix_word  = PW'({shreg, data_s});
   assign pix_done  = cap && (phase_cur == PH_END);
   assign in_range  = (x_cur < H_LIM) && (y_cnt < V_LIM);

`ifdef CAM_CAPTURE_CROP_EN
   assign in_win = in_range
                   && (x_cur[XW-1:0] >= win_x0) && (x_cur[XW-1:0] <= win_x1)
                   && (y_cnt[YW-1:0] >= win_y0) && (y_cnt[YW-1:0] <= win_y1);
   assign eol_px = (x_cur[XW-1:0] == win_x1);
`else
   logic unused_win;
   assign unused_win = ^{win_x0, win_x1, win_y0, win_y1};
   assign in_win     = in_range;
   assign eol_px     = (x_cur == H_LAST);
`endif

   assign fwd = pix_done && in_win;

   always_comb begin
      new_rec      = '0;
      new_rec.data = pix_word;
      new_rec.x    = x_cur[XW-1:0];
      new_rec.y    = y_cnt[YW-1:0];
      new_rec.sof  = sof_pend;
      new_rec.eol  = eol_px;
   end

   // Without cropping, a pixel is held one slot so the line end can still tag it eol.
   always_comb begin
      wr_en        = 1'b0;
      wr_rec       = pend_rec;
      pend_valid_n = pend_valid;
`ifdef CAM_CAPTURE_CROP_EN
      wr_en        = pend_valid;
      pend_valid_n = fwd;
`else
      wr_en        = pend_valid & (fwd | end_line | abort);
      wr_rec.eol   = pend_rec.eol | end_line | abort;
      pend_valid_n = fwd | (pend_valid & ~wr_en);
`endif
   end

   always_ff @(posedge clk) begin
      if (res) begin
         state      <= ST_IDLE;
         phase      <= '0;
         shreg      <= '0;
         x_cnt      <= '0;
         y_cnt      <= '0;
         sof_pend   <= 1'b0;
         frame_cnt  <= '0;
         pend_valid <= 1'b0;
         pend_rec   <= '0;
         overflow   <= 1'b0;
      end else begin
         state      <= state_n;
         pend_valid <= pend_valid_n;
         if (start_frame) begin
            frame_cnt <= frame_cnt + 16'd1;
            y_cnt     <= '0;
            sof_pend  <= 1'b1;
         end
         if (cap) begin
            shreg <= pix_word;
            phase <= pix_done ? '0 : phase_cur + PHW'(1);
            if (pix_done) x_cnt <= (x_cur == H_LIM) ? x_cur : x_cur + (XW+1)'(1);
            else          x_cnt <= x_cur;
         end
         if (fwd) begin
            sof_pend <= 1'b0;
            pend_rec <= new_rec;
         end
         if (end_line && (y_cnt != V_LIM)) y_cnt <= y_cnt + (YW+1)'(1);
         overflow <= (wr_en & full & ~pix_ready) | (overflow & ~clear_ovf);
      end
   end

   cam_sync_fifo #(
      .W     (RW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .res     (res),
      .wr_en   (wr_en),
      .wr_data (wr_rec),
      .rd_en   (pix_ready),
      .rd_data (rd_bits),
      .full    (full),
      .empty   (empty)
   );

   assign rd_rec    = rd_bits;
   assign out_rec   = empty ? '0 : rd_rec;
   assign pix_valid = ~empty;
   assign pix_data  = out_rec.data;
   assign pix_x     = out_rec.x;
   assign pix_y     = out_rec.y;
   assign pix_sof   = out_rec.sof;
   assign pix_eol   = out_rec.eol;
   assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_cam_capture_frontend.sv
// tb/tb_cam_capture_frontend.sv - bench for cam_capture_frontend (either CAM_CAPTURE_CROP_EN build)
module tb_cam_capture_frontend;
   import cam_capture_pkg::*;

   localparam int DW = 8, BPP = 2, HM = 640, VM = 480, DEPTH = 8, XDIV = 4;
`ifdef CAM_CAPTURE_CROP_EN
   localparam bit CROP = 1'b1;
`else
   localparam bit CROP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          res = 1'b1;
   logic          xclk;
   logic          cam_href = 1'b0, cam_vsync = 1'b1, cam_pclk = 1'b0;
   logic [7:0]    cam_data = '0;
   logic          enable = 1'b1;
   logic [9:0]    win_x0 = '0, win_x1 = 10'd639;
   logic [8:0]    win_y0 = '0, win_y1 = 9'd479;
   logic [15:0]   pix_data;
   logic [9:0]    pix_x;
   logic [8:0]    pix_y;
   logic          pix_sof, pix_eol, pix_valid, busy, overflow;
   logic          pix_ready = 1'b1, clear_ovf = 1'b0;
   logic [15:0]   frame_cnt;

   always #5 clk = ~clk;

   cam_capture_frontend #(
      .DATA_W(DW), .BYTES_PER_PIX(BPP), .XCLK_DIV(XDIV),
      .H_MAX(HM), .V_MAX(VM), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .res(res), .xclk(xclk),
      .cam_href(cam_href), .cam_vsync(cam_vsync), .cam_pclk(cam_pclk), .cam_data(cam_data),
      .enable(enable), .win_x0(win_x0), .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1),
      .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof), .pix_eol(pix_eol),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .busy(busy), .overflow(overflow),
      .clear_ovf(clear_ovf), .frame_cnt(frame_cnt)
   );

   int         n_vec = 0, n_bad = 0, rx_cnt = 0;
   pix_rec_t   sb[$];
   pix_rec_t   mon_e;
   logic [7:0] bval;
   int         my;
   bit         m_sof, m_active;

   typedef struct {
      int lines;
      int nbytes;
      int wx0, wx1, wy0, wy1;
      int exp_pix;
   } vec_t;
   vec_t tbl[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!res && pix_valid && pix_ready) begin
         rx_cnt++;
         if (sb.size() == 0) begin
            chk("unexpected_pixel", 32'(pix_data), 32'hFFFF_FFFF);
         end else begin
            mon_e = sb.pop_front();
            chk("pix_data", 32'(pix_data), 32'(mon_e.data));
            chk("pix_x",    32'(pix_x),    32'(mon_e.x));
            chk("pix_y",    32'(pix_y),    32'(mon_e.y));
            chk("pix_sof",  32'(pix_sof),  32'(mon_e.sof));
            chk("pix_eol",  32'(pix_eol),  32'(mon_e.eol));
         end
      end
   end

   task automatic pulse(input logic hr, input logic [7:0] d);
      cam_href = hr;
      cam_data = d;
      repeat (4) tick();
      cam_pclk = 1'b1;
      repeat (4) tick();
      cam_pclk = 1'b0;
   endtask

   task automatic frame_start();
      cam_vsync = 1'b1;
      pulse(1'b0, 8'h00);
      pulse(1'b0, 8'h00);
      cam_vsync = 1'b0;
      m_active  = enable;
      m_sof     = 1'b1;
      my        = 0;
      bval      = 8'h01;
      pulse(1'b0, 8'h00);
      pulse(1'b0, 8'h00);
   endtask

   task automatic frame_end();
      cam_vsync = 1'b1;
      pulse(1'b0, 8'h00);
   endtask

   task automatic send_line(input int nbytes, input bit abort);
      int         npx = nbytes / BPP;
      int         x;
      int         k;
      bit         fwd;
      logic [7:0] prev;
      pix_rec_t   e;
      prev = 8'h00;
      for (int i = 0; i < nbytes; i++) begin
         if (m_active && (i % 2 == 1)) begin
            x = i / 2;
            if (CROP) begin
               fwd   = (x >= int'(win_x0)) && (x <= int'(win_x1)) && (my >= int'(win_y0)) && (my <= int'(win_y1));
               e.eol = (x == int'(win_x1));
            end else begin
               fwd   = 1'b1;
               e.eol = (x == npx - 1) || (x == HM - 1);
            end
            if (fwd) begin
               e.data = {prev, bval};
               e.x    = 10'(x);
               e.y    = 9'(my);
               e.sof  = m_sof;
               m_sof  = 1'b0;
               sb.push_back(e);
            end
         end
         prev = bval;
         pulse(1'b1, bval);
         bval = bval + 8'd1;
      end
      if (abort) begin
         cam_vsync = 1'b1;
         k = 0;
         while (busy && k < 4) begin
            tick();
            k++;
         end
         chk("busy_after_abort", 32'(busy), 32'd0);
      end
      pulse(1'b0, 8'h00);
      pulse(1'b0, 8'h00);
      my++;
   endtask

   task automatic wait_drain();
      int k = 0;
      while (sb.size() != 0 && k < 3000) begin
         tick();
         k++;
      end
      chk("drain_done", 32'(sb.size()), 32'd0);
      repeat (20) tick();
   endtask

   initial begin
      int rx0;
      int k;
      tbl[0] = '{3, 8, 0, 639, 0, 479, 12};
      tbl[1] = '{3, 8, 0, 639, 0, 479, 12};
      tbl[2] = '{3, 8, 1, 2, 1, 1, CROP ? 2 : 12};
      tbl[3] = '{2, 3, 0, 639, 0, 479, 2};
      tbl[4] = '{2, 7, 0, 0, 0, 1, CROP ? 2 : 6};

      repeat (4) tick();
      chk("rst_xclk",      32'(xclk),      32'd0);
      chk("rst_pix_valid", 32'(pix_valid), 32'd0);
      chk("rst_pix_data",  32'(pix_data),  32'd0);
      chk("rst_pix_x",     32'(pix_x),     32'd0);
      chk("rst_pix_sof",   32'(pix_sof),   32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_overflow",  32'(overflow),  32'd0);
      chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      res = 1'b0;

      for (int n = 0; n < 2; n++) begin
         k = 0;
         while (xclk == 1'b0 && k < 10) begin tick(); k++; end
         k = 0;
         while (xclk == 1'b1 && k < 10) begin tick(); k++; end
         chk("xclk_half_period", 32'(k), 32'(XDIV / 2));
      end

      for (int i = 0; i < 5; i++) begin
         win_x0 = 10'(tbl[i].wx0);
         win_x1 = 10'(tbl[i].wx1);
         win_y0 = 9'(tbl[i].wy0);
         win_y1 = 9'(tbl[i].wy1);
         rx0    = rx_cnt;
         frame_start();
         for (int l = 0; l < tbl[i].lines; l++) send_line(tbl[i].nbytes, 1'b0);
         frame_end();
         wait_drain();
         chk("vec_pix_count", 32'(rx_cnt - rx0), 32'(tbl[i].exp_pix));
         chk("vec_frame_cnt", 32'(frame_cnt),    32'(i + 1));
         chk("vec_overflow",  32'(overflow),     32'd0);
      end

      win_x0 = '0; win_x1 = 10'd639; win_y0 = '0; win_y1 = 9'd479;

      pix_ready = 1'b0;
      rx0 = rx_cnt;
      frame_start();
      for (int l = 0; l < 3; l++) send_line(8, 1'b0);
      frame_end();
      while (sb.size() > DEPTH) void'(sb.pop_back());
      repeat (5) tick();
      chk("stall_valid",    32'(pix_valid), 32'd1);
      chk("stall_data",     32'(pix_data),  32'h0102);
      chk("stall_sof",      32'(pix_sof),   32'd1);
      chk("overflow_set",   32'(overflow),  32'd1);
      repeat (10) tick();
      chk("stall_hold_data", 32'(pix_data), 32'(sb[0].data));
      chk("stall_hold_x",    32'(pix_x),    32'(sb[0].x));
      clear_ovf = 1'b1;
      tick();
      clear_ovf = 1'b0;
      tick();
      chk("overflow_clear", 32'(overflow), 32'd0);
      pix_ready = 1'b1;
      wait_drain();
      chk("stall_pix_count", 32'(rx_cnt - rx0), 32'(DEPTH));
      chk("stall_frame_cnt", 32'(frame_cnt),    32'd6);

      rx0 = rx_cnt;
      frame_start();
      send_line(8, 1'b0);
      send_line(5, 1'b1);
      frame_end();
      wait_drain();
      chk("abort_pix_count", 32'(rx_cnt - rx0), 32'd6);
      chk("abort_frame_cnt", 32'(frame_cnt),    32'd7);

      enable = 1'b0;
      rx0 = rx_cnt;
      frame_start();
      send_line(8, 1'b0);
      frame_end();
      repeat (40) tick();
      chk("disabled_pix_count", 32'(rx_cnt - rx0), 32'd0);
      chk("disabled_frame_cnt", 32'(frame_cnt),    32'd7);
      chk("disabled_busy",      32'(busy),         32'd0);
      enable = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not complete, %0d vectors applied", n_vec);
      $fatal(1);
   end

endmodule
